// File: rtl/intan_fifo_sched_if.sv
// Bus bundle between the four Intan ADC frame sources and the shared FIFO
// write port. The scheduler takes the slave side; a source/FIFO model takes master.
interface intan_fifo_sched_if;
  logic [3:0]  fs_adc;
  logic [3:0]  fd_adc;
  logic [3:0]  adc_rxen;
  logic [31:0] adc_rxd;
  logic [7:0]  frame_len;
  logic        fifo_full;
  logic [7:0]  fifo_txd;
  logic        fifo_txen;
  logic [7:0]  show_state;

  modport master (
    output fs_adc, adc_rxd, frame_len, fifo_full,
    input  fd_adc, adc_rxen, fifo_txd, fifo_txen, show_state
  );

  modport slave (
    input  fs_adc, adc_rxd, frame_len, fifo_full,
    output fd_adc, adc_rxen, fifo_txd, fifo_txen, show_state
  );
endinterface

// File: rtl/intan_fifo_sched.sv
// Round-robin frame scheduler: moves one complete frame (header byte + frame_len
// data bytes) from the granted ADC source into the shared FIFO, never interleaving.
module intan_fifo_sched (
  input  logic              clk,
  input  logic              rst_n,
  intan_fifo_sched_if.slave bus
);

  localparam int DATA_W = 8;
  localparam int SRC_N  = 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARB  = 3'd1;
  localparam logic [2:0] S_HEAD = 3'd2;
  localparam logic [2:0] S_READ = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state;
  logic [1:0]        grant;
  logic [1:0]        last_grant;
  logic [1:0]        rr_pick;
  logic [7:0]        len;
  logic [7:0]        count;
  logic [7:0]        count_inc;
  logic              rd_fire;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] txd;
  logic              txen;

  // Walk backwards so the source closest after last_grant wins; last_grant
  // itself is the lowest-priority candidate.
  always_comb begin
    rr_pick = last_grant;
    for (int k = SRC_N; k >= 1; k--) begin
      if (bus.fs_adc[last_grant + 2'(k)]) rr_pick = last_grant + 2'(k);
    end
  end

  assign rd_fire   = (state == S_READ) && !bus.fifo_full && (count < len);
  assign count_inc = count + 8'd1;
  assign lane      = bus.adc_rxd[DATA_W*grant +: DATA_W];

  assign bus.adc_rxen   = rd_fire ? (4'b0001 << grant) : 4'b0000;
  assign bus.fd_adc     = (state == S_DONE) ? (4'b0001 << grant) : 4'b0000;
  assign bus.show_state = {5'b00000, state};
  assign bus.fifo_txd   = txd;
  assign bus.fifo_txen  = txen;

  // Grant and length are captured once per frame; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (state == S_ARB && (|bus.fs_adc)) begin
      grant <= rr_pick;
      len   <= bus.frame_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= 2'd3;
      count      <= 8'd0;
      txd        <= '0;
      txen       <= 1'b0;
    end else begin
      txen <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bus.fs_adc) state <= S_ARB;
        end
        S_ARB: begin
          state <= (|bus.fs_adc) ? S_HEAD : S_IDLE;
        end
        S_HEAD: begin
          if (!bus.fifo_full) begin
            txd   <= {4'hA, 2'b00, grant};
            txen  <= 1'b1;
            state <= (len == 8'd0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          if (rd_fire) begin
            txd   <= lane;
            txen  <= 1'b1;
            count <= count_inc;
            if (count_inc == len) state <= S_DONE;
          end else if (count >= len) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          last_grant <= grant;
          count      <= 8'd0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_rxen_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.adc_rxen));
  a_rxen_full: assert property (@(posedge clk) disable iff (!rst_n)
    bus.fifo_full |-> (bus.adc_rxen == 4'b0000));
  a_fd_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.fd_adc));

endmodule

// File: doc/intan_fifo_sched.md
INTAN_FIFO_SCHED -- requirements
Module: intan_fifo_sched

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: fs_adc  input  4  per-source frame-ready level; bit i = ADC source i holds a complete frame.
REQ-004 SHALL have port: fd_adc  output  4  per-source frame-done pulse, one-hot, one cycle.
REQ-005 SHALL have port: adc_rxen  output  4  one-hot byte read enable to granted source.
REQ-006 SHALL have port: adc_rxd  input  32  byte lanes, source i on bits [8i+7:8i]; lane valid combinationally while its adc_rxen bit is high.
REQ-007 SHALL have port: frame_len  input  8  data bytes per frame, sampled at grant.
REQ-008 SHALL have port: fifo_full  input  1  shared FIFO write port full.
REQ-009 SHALL have port: fifo_txd  output  8  byte to shared FIFO.
REQ-010 SHALL have port: fifo_txen  output  1  FIFO write strobe, one byte per high cycle.
REQ-011 SHALL have port: show_state  output  8  current state code, zero-extended.

Function
REQ-012 SHALL implement states IDLE(0), ARB(1), HEAD(2), READ(3), DONE(4); unused codes SHALL go to IDLE.
REQ-013 IDLE -> ARB when any fs_adc bit high; else stay.
REQ-014 ARB SHALL grant round-robin: search starts at last_grant+1 mod 4; granted index and frame_len latched; -> HEAD. If fs_adc dropped to zero, -> IDLE, no grant.
REQ-015 HEAD SHALL, in a cycle with fifo_full low, register fifo_txd = {4'hA, 2'b00, grant[1:0]} and fifo_txen = 1 on that edge; -> READ, or -> DONE if latched length = 0. With fifo_full high, stay, no write.
REQ-016 READ: adc_rxen[grant] = (state==READ) && !fifo_full && count < length, combinational; all other bits 0.
REQ-017 On each edge with adc_rxen[grant] high: fifo_txd <= granted lane, fifo_txen <= 1, count += 1 (8-bit); write latency = 1 cycle after rxen.
REQ-018 fifo_txen SHALL be 0 in every cycle not following a header or read strobe.
REQ-019 READ -> DONE on the edge where count reaches length.
REQ-020 DONE SHALL pulse fd_adc[grant] for exactly one cycle, update last_grant = grant, clear count, -> IDLE.
REQ-021 Frame SHALL never be interleaved: fs_adc changes of other sources during HEAD/READ/DONE are ignored until the next ARB.
REQ-022 fs_adc of the granted source dropping mid-frame SHALL NOT abort the frame.
REQ-023 fifo_full stalls HEAD/READ indefinitely without data loss or duplicate writes; frame_len changes after grant have no effect.
REQ-024 frame_len = 255 SHALL read exactly 255 bytes (no counter wrap).

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, last_grant = 3 (source 0 first priority), count = 0, fifo_txd = 0, fifo_txen = 0, fd_adc = 0; adc_rxen = 0 via state.
REQ-026 Reset mid-frame SHALL abandon the frame with no fd_adc pulse; first frame after release starts from IDLE.

Verification
REQ-027 fs_adc=4'b0001, frame_len=3, fifo_full=0, lane0 = 8'h11,8'h22,8'h33 -> FIFO receives A0,11,22,33 on consecutive cycles, fd_adc=0001 one cycle, show_state returns 0.
REQ-028 fs_adc=4'b1111 held, frame_len=1 -> grant order 0,1,2,3,0; headers A0,A1,A2,A3,A0.
REQ-029 fs_adc=4'b0100, frame_len=4, fifo_full high for 3 cycles after 2nd data byte -> adc_rxen low those 3 cycles; exactly 5 writes total, byte order intact.
REQ-030 frame_len=0, fs_adc=4'b0010 -> single write A1, fd_adc=0010, no adc_rxen pulse.
REQ-031 rst_n low during READ with count=2 of 5 -> outputs zero asynchronously, no fd_adc; after release with fs_adc=4'b1000 grant = 3 only if source 0-2 idle, header A3.
